// File: rtl/sp_dram_arb_if.sv
// sp_dram_arb_if: requester-side and DRAM-side signals of the single-port DRAM arbiter
interface sp_dram_arb_if #(
    parameter int PORTS      = 2,
    parameter int ADDR_WIDTH = 25,
    parameter int DATA_WIDTH = 128,
    parameter int MASK_WIDTH = 16
);
    logic [PORTS-1:0]            req;
    logic [PORTS-1:0]            req_we;
    logic [PORTS*ADDR_WIDTH-1:0] req_addr;
    logic [PORTS*DATA_WIDTH-1:0] req_din;
    logic [PORTS*MASK_WIDTH-1:0] req_mask;
    logic [PORTS-1:0]            ack;
    logic [PORTS-1:0]            rd_valid;
    logic [DATA_WIDTH-1:0]       rd_data;
    logic [ADDR_WIDTH-1:0]       mem_addr;
    logic [DATA_WIDTH-1:0]       mem_din;
    logic [MASK_WIDTH-1:0]       mem_mask;
    logic                        mem_we;
    logic                        mem_re;
    logic [DATA_WIDTH-1:0]       mem_dout;
    logic                        mem_ready;

    modport slave (
        input  req, req_we, req_addr, req_din, req_mask, mem_dout, mem_ready,
        output ack, rd_valid, rd_data, mem_addr, mem_din, mem_mask, mem_we, mem_re
    );

    modport master (
        output req, req_we, req_addr, req_din, req_mask, mem_dout, mem_ready,
        input  ack, rd_valid, rd_data, mem_addr, mem_din, mem_mask, mem_we, mem_re
    );
endinterface

// File: rtl/sp_dram_arb.sv
// sp_dram_arb: round-robin arbiter sharing one DRAM command port between PORTS requesters
module sp_dram_arb #(
    parameter int PORTS      = 2,
    parameter int ADDR_WIDTH = 25,
    parameter int DATA_WIDTH = 128,
    parameter int MASK_WIDTH = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    sp_dram_arb_if.slave  bus
);
    localparam int PW = PORTS > 1 ? $clog2(PORTS) : 1;

    typedef enum logic [1:0] {IDLE, ISSUE, GAP, WAIT_RD} state_t;

    state_t                 state_q, state_d;
    logic [PW-1:0]          last_q, last_d, g_q, g_d, pick, idx;
    logic                   found, we_q, we_d;
    logic [PORTS-1:0]       ack_q, ack_d, rv_q, rv_d;
    logic                   mem_we_q, mem_we_d, mem_re_q, mem_re_d;
    logic [ADDR_WIDTH-1:0]  addr_q, addr_d;
    logic [DATA_WIDTH-1:0]  din_q, din_d, rd_q, rd_d;
    logic [MASK_WIDTH-1:0]  mask_q, mask_d;
    logic [ADDR_WIDTH-1:0]  addr_a [PORTS];
    logic [DATA_WIDTH-1:0]  din_a  [PORTS];
    logic [MASK_WIDTH-1:0]  mask_a [PORTS];

    for (genvar i = 0; i < PORTS; i++) begin : g_unpack
        assign addr_a[i] = bus.req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
        assign din_a[i]  = bus.req_din[i*DATA_WIDTH +: DATA_WIDTH];
        assign mask_a[i] = bus.req_mask[i*MASK_WIDTH +: MASK_WIDTH];
    end

    // Round-robin search: first requesting port after the last grant, wrapping modulo PORTS
    always_comb begin
        found = 1'b0;
        pick  = last_q;
        idx   = last_q;
        for (int k = 1; k <= PORTS; k++) begin
            idx = PW'((32'(last_q) + 32'(k)) % PORTS);
            if (!found && bus.req[idx]) begin
                found = 1'b1;
                pick  = idx;
            end
        end
    end

    // Next state and next registered outputs; strobes and pulses default low every cycle
    always_comb begin
        state_d  = state_q;
        last_d   = last_q;
        g_d      = g_q;
        we_d     = we_q;
        ack_d    = '0;
        rv_d     = '0;
        mem_we_d = 1'b0;
        mem_re_d = 1'b0;
        addr_d   = addr_q;
        din_d    = din_q;
        mask_d   = mask_q;
        rd_d     = rd_q;
        case (state_q)
            IDLE: if (bus.mem_ready && found) begin
                state_d     = ISSUE;
                g_d         = pick;
                last_d      = pick;
                we_d        = bus.req_we[pick];
                addr_d      = addr_a[pick];
                din_d       = din_a[pick];
                mask_d      = mask_a[pick];
                ack_d[pick] = 1'b1;
                mem_we_d    = bus.req_we[pick];
                mem_re_d    = !bus.req_we[pick];
            end
            ISSUE:   state_d = GAP;
            GAP:     state_d = we_q ? IDLE : WAIT_RD;
            WAIT_RD: if (bus.mem_ready) begin
                state_d   = IDLE;
                rd_d      = bus.mem_dout;
                rv_d[g_q] = 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

    // State and output registers; reset abandons any operation in flight
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            last_q   <= PW'(PORTS - 1);
            g_q      <= '0;
            we_q     <= 1'b0;
            ack_q    <= '0;
            rv_q     <= '0;
            mem_we_q <= 1'b0;
            mem_re_q <= 1'b0;
            addr_q   <= '0;
            din_q    <= '0;
            mask_q   <= '0;
            rd_q     <= '0;
        end else begin
            state_q  <= state_d;
            last_q   <= last_d;
            g_q      <= g_d;
            we_q     <= we_d;
            ack_q    <= ack_d;
            rv_q     <= rv_d;
            mem_we_q <= mem_we_d;
            mem_re_q <= mem_re_d;
            addr_q   <= addr_d;
            din_q    <= din_d;
            mask_q   <= mask_d;
            rd_q     <= rd_d;
        end
    end

    assign bus.ack      = ack_q;
    assign bus.rd_valid = rv_q;
    assign bus.rd_data  = rd_q;
    assign bus.mem_addr = addr_q;
    assign bus.mem_din  = din_q;
    assign bus.mem_mask = mask_q;
    assign bus.mem_we   = mem_we_q;
    assign bus.mem_re   = mem_re_q;
endmodule
